// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit, CSR and fetch-redirect signals of the trap sequencer.
interface trap_ctrl_if #(parameter int MXLEN = 64);
    logic             commit_valid;
    logic [MXLEN-1:0] commit_pc;
    logic             exc_valid;
    logic [5:0]       exc_cause;
    logic [MXLEN-1:0] exc_tval;
    logic             mret_valid;
    logic [MXLEN-1:0] mstatus_i;
    logic [MXLEN-1:0] mie_i;
    logic [MXLEN-1:0] mip_i;
    logic [MXLEN-1:0] mtvec_i;
    logic [MXLEN-1:0] mepc_i;
    logic             pipe_idle;
    logic             redirect_ready;
    logic             busy;
    logic             flush;
    logic             csr_we;
    logic [MXLEN-1:0] mepc_o;
    logic [MXLEN-1:0] mcause_o;
    logic [MXLEN-1:0] mtval_o;
    logic [MXLEN-1:0] mstatus_o;
    logic             redirect_valid;
    logic [MXLEN-1:0] redirect_pc;
    logic [1:0]       priv_o;

    modport master (
        output commit_valid, commit_pc, exc_valid, exc_cause, exc_tval, mret_valid,
               mstatus_i, mie_i, mip_i, mtvec_i, mepc_i, pipe_idle, redirect_ready,
        input  busy, flush, csr_we, mepc_o, mcause_o, mtval_o, mstatus_o,
               redirect_valid, redirect_pc, priv_o
    );
    modport slave (
        input  commit_valid, commit_pc, exc_valid, exc_cause, exc_tval, mret_valid,
               mstatus_i, mie_i, mip_i, mtvec_i, mepc_i, pipe_idle, redirect_ready,
        output busy, flush, csr_we, mepc_o, mcause_o, mtval_o, mstatus_o,
               redirect_valid, redirect_pc, priv_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap/MRET sequencer; drains, writes trap CSRs in one cycle, redirects fetch.
module trap_ctrl #(
    parameter int               MXLEN            = 64,
    parameter logic [1:0]       RESET_PRIV       = 2'b11,
    parameter logic [MXLEN-1:0] MTVEC_ALIGN_MASK = ~MXLEN'(3)
) (
    input  logic clk,
    input  logic reset_n,
    trap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, WRITE, REDIRECT} state_t;
    state_t           state_q, state_d;
    logic [1:0]       priv_q, priv_d;
    logic             mret_q, mret_d, irq_q, irq_d;
    logic [5:0]       code_q, code_d;
    logic [MXLEN-1:0] pc_q, pc_d, tval_q, tval_d, rpc_q, rpc_d;
    logic [11:0]      pend;
    logic             irq, take;
    logic [5:0]       irq_code;
    logic [MXLEN-1:0] base, mst_trap, mst_mret;
    logic             unused_bits;

    assign unused_bits = ^{bus.mie_i[MXLEN-1:12], bus.mip_i[MXLEN-1:12]};
    assign pend        = bus.mie_i[11:0] & bus.mip_i[11:0] & 12'h888;
    assign irq         = (priv_q != 2'b11 || bus.mstatus_i[3]) && |pend;
    assign irq_code    = pend[11] ? 6'd11 : pend[3] ? 6'd3 : 6'd7;
    assign take        = bus.commit_valid && (irq || bus.exc_valid || bus.mret_valid);
    assign base        = bus.mtvec_i & MTVEC_ALIGN_MASK;

    // mstatus MIE=3, MPIE=7, MPP=12:11
    always_comb begin
        mst_trap        = bus.mstatus_i;
        mst_trap[7]     = bus.mstatus_i[3];
        mst_trap[3]     = 1'b0;
        mst_trap[12:11] = priv_q;
        mst_mret        = bus.mstatus_i;
        mst_mret[3]     = bus.mstatus_i[7];
        mst_mret[7]     = 1'b1;
        mst_mret[12:11] = 2'b00;
    end

    always_comb begin
        state_d = state_q;
        priv_d  = priv_q;
        mret_d  = mret_q;
        irq_d   = irq_q;
        code_d  = code_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        rpc_d   = rpc_q;
        case (state_q)
            IDLE: if (take) begin
                state_d = DRAIN;
                irq_d   = irq;
                mret_d  = !irq && !bus.exc_valid;
                code_d  = irq ? irq_code : bus.exc_cause;
                pc_d    = bus.commit_pc;
                tval_d  = irq ? '0 : bus.exc_tval;
            end
            DRAIN: if (bus.pipe_idle) state_d = WRITE;
            WRITE: begin
                state_d = REDIRECT;
                priv_d  = mret_q ? bus.mstatus_i[12:11] : 2'b11;
                rpc_d   = mret_q ? {bus.mepc_i[MXLEN-1:2], 2'b00}
                        : (irq_q && bus.mtvec_i[1:0] == 2'b01) ? base + MXLEN'({code_q, 2'b00}) : base;
            end
            REDIRECT: if (bus.redirect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            priv_q  <= RESET_PRIV;
            mret_q  <= 1'b0;
            irq_q   <= 1'b0;
            code_q  <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            priv_q  <= priv_d;
            mret_q  <= mret_d;
            irq_q   <= irq_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            rpc_q   <= rpc_d;
        end
    end

    // Outputs decode from state so an async reset silences them immediately
    assign bus.busy           = state_q != IDLE;
    assign bus.flush          = state_q == IDLE && take;
    assign bus.csr_we         = state_q == WRITE;
    assign bus.mepc_o         = !bus.csr_we ? '0 : mret_q ? bus.mepc_i : pc_q;
    assign bus.mcause_o       = bus.csr_we && !mret_q ? {irq_q, {(MXLEN-7){1'b0}}, code_q} : '0;
    assign bus.mtval_o        = bus.csr_we && !mret_q ? tval_q : '0;
    assign bus.mstatus_o      = !bus.csr_we ? '0 : mret_q ? mst_mret : mst_trap;
    assign bus.redirect_valid = state_q == REDIRECT;
    assign bus.redirect_pc    = bus.redirect_valid ? rpc_q : '0;
    assign bus.priv_o         = priv_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench; driver pushes modelled trap/MRET results, monitor checks CSR writes and redirects.
module tb_trap_ctrl;
    typedef struct {
        bit        mret;
        bit [63:0] mepc, mcause, mtval, mstatus, rpc;
        bit [1:0]  priv;
    } exp_t;

    logic clk = 0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    int   we_cnt = 0;
    bit   rnd_hs = 0;
    bit [1:0] priv_m = 2'b11;
    exp_t sb[$];

    trap_ctrl_if bus();
    trap_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    // Reference: decide the event from the architectural rules, then build the CSR bundle arithmetically
    function automatic void model(input bit [1:0] priv, input bit cv, exc, mret,
                                  input bit [5:0] cause, input bit [63:0] pc, tval,
                                  mst, mie, mip, mtvec, mepc, output exp_t e, output bit tk);
        bit [63:0] en = mie & mip;
        int code = -1;
        if (priv != 2'b11 || mst[3]) begin
            if (en[11]) code = 11;
            else if (en[3]) code = 3;
            else if (en[7]) code = 7;
        end
        tk = cv && (code >= 0 || exc || mret);
        if (code >= 0 || exc) begin
            e.mret    = 0;
            e.mepc    = pc;
            e.mcause  = code >= 0 ? (64'h1 << 63) + 64'(code) : 64'(cause);
            e.mtval   = code >= 0 ? 64'h0 : tval;
            e.mstatus = (mst & ~64'h1888) | (64'(mst[3]) << 7) | (64'(priv) << 11);
            e.rpc     = mtvec - mtvec % 4;
            if (code >= 0 && mtvec % 4 == 1) e.rpc += 64'(4 * code);
            e.priv    = 2'b11;
        end else begin
            e.mret    = 1;
            e.mepc    = mepc;
            e.mcause  = 0;
            e.mtval   = 0;
            e.mstatus = (mst & ~64'h1888) | (64'(mst[7]) << 3) | 64'h80;
            e.rpc     = mepc - mepc % 4;
            e.priv    = mst[12:11];
        end
    endfunction

    task automatic set_csr(bit [63:0] mst, mie, mip, mtvec, mepc);
        bus.mstatus_i = mst;
        bus.mie_i     = mie;
        bus.mip_i     = mip;
        bus.mtvec_i   = mtvec;
        bus.mepc_i    = mepc;
    endtask

    // Called just after a posedge with the DUT idle; returns one edge later
    task automatic start(bit cv, bit [63:0] pc, bit exc, bit [5:0] cause, bit [63:0] tval, bit mret);
        exp_t e;
        bit tk;
        bus.commit_valid = cv;
        bus.commit_pc    = pc;
        bus.exc_valid    = exc;
        bus.exc_cause    = cause;
        bus.exc_tval     = tval;
        bus.mret_valid   = mret;
        model(priv_m, cv, exc, mret, cause, pc, tval, bus.mstatus_i, bus.mie_i,
              bus.mip_i, bus.mtvec_i, bus.mepc_i, e, tk);
        @(negedge clk);
        chk("flush", bus.flush, 64'(tk));
        chk("idle_busy", bus.busy, 0);
        if (tk) begin
            sb.push_back(e);
            priv_m = e.priv;
        end
        @(posedge clk);
        #1;
        if (tk) begin
            bus.commit_valid = 1'($urandom_range(0, 1));
            bus.exc_valid    = 1'($urandom_range(0, 1));
            bus.mret_valid   = 1'($urandom_range(0, 1));
            bus.commit_pc    = {$urandom, $urandom};
        end
    endtask

    task automatic finish();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 64'(sb.size()), 0);
        sb.delete();
        bus.commit_valid = 0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_hs) begin
            bus.pipe_idle      = $urandom_range(0, 2) != 0;
            bus.redirect_ready = $urandom_range(0, 2) != 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (bus.csr_we) begin
                we_cnt++;
                chk("we_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("mepc", bus.mepc_o, sb[0].mepc);
                    chk("mstatus", bus.mstatus_o, sb[0].mstatus);
                    if (!sb[0].mret) begin
                        chk("mcause", bus.mcause_o, sb[0].mcause);
                        chk("mtval", bus.mtval_o, sb[0].mtval);
                    end
                end
            end
            if (bus.redirect_valid) begin
                chk("rv_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("redirect_pc", bus.redirect_pc, sb[0].rpc);
                    chk("rv_busy", bus.busy, 1);
                    if (bus.redirect_ready) begin
                        chk("priv", bus.priv_o, sb[0].priv);
                        chk("we_once", 64'(we_cnt), 1);
                        we_cnt = 0;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 0;
        bus.commit_valid = 0; bus.commit_pc = 0; bus.exc_valid = 0; bus.exc_cause = 0;
        bus.exc_tval = 0; bus.mret_valid = 0; bus.pipe_idle = 1; bus.redirect_ready = 1;
        set_csr(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_priv", bus.priv_o, 2'b11);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.csr_we, 0);
        chk("rst_rv", bus.redirect_valid, 0);
        reset_n = 1;
        @(posedge clk);
        #1;
        set_csr(64'h8, 0, 0, 64'h8000_0000, 0);
        start(1, 64'h8000_0100, 1, 2, 64'hdead, 0); finish();
        set_csr(64'h8, 64'h80, 64'h80, 64'h8000_0001, 0);
        start(1, 64'h8000_0200, 0, 0, 0, 0); finish();
        set_csr(64'h8, 64'h888, 64'h888, 64'h8000_0000, 0);
        start(1, 64'h8000_0300, 1, 5, 64'h1234, 0); finish();
        set_csr(64'h8, 64'h808, 64'h808, 64'hffff_ffff_ffff_fffd, 0);
        start(1, 64'h8000_0400, 0, 0, 0, 0); finish();
        set_csr(0, 64'h800, 64'h800, 64'h8000_0000, 0);
        start(1, 64'h8000_0500, 0, 0, 0, 0); finish();
        set_csr(64'h8, 0, 0, 64'h8000_0000, 0);
        start(0, 64'h8000_0600, 1, 3, 0, 0); finish();
        set_csr(64'h80, 0, 0, 64'h8000_0000, 64'h8000_0203);
        start(1, 64'h8000_0700, 0, 0, 0, 1); finish();
        chk("mret_priv", bus.priv_o, 2'b00);
        // Reset lands while the CSR write strobe is up
        set_csr(0, 0, 0, 64'h8000_0000, 0);
        start(1, 64'h8000_0800, 1, 2, 5, 0);
        @(posedge clk);
        #1;
        chk("write_we", bus.csr_we, 1);
        chk("write_priv_old", bus.priv_o, 2'b00);
        #3 reset_n = 0;
        #1;
        chk("rst_mid_we", bus.csr_we, 0);
        chk("rst_mid_rv", bus.redirect_valid, 0);
        chk("rst_mid_priv", bus.priv_o, 2'b11);
        chk("rst_mid_busy", bus.busy, 0);
        sb.delete();
        we_cnt = 0;
        priv_m = 2'b11;
        bus.commit_valid = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 0);
        // Drain and fetch back-pressure
        set_csr(64'h8, 0, 0, 64'h8000_1000, 0);
        start(1, 64'h8000_0900, 1, 4, 64'h77, 0);
        bus.pipe_idle = 0;
        bus.redirect_ready = 0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_busy", bus.busy, 1);
            chk("stall_no_we", bus.csr_we, 0);
            @(posedge clk);
            #1;
        end
        bus.pipe_idle = 1;
        for (int i = 0; i < 10 && !bus.redirect_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_rv", bus.redirect_valid, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.redirect_ready = 1;
        finish();
        rnd_hs = 1;
        repeat (300) begin
            set_csr({$urandom, $urandom},
                    64'($urandom) & ($urandom_range(0, 1) ? 64'h888 : 64'hfff),
                    64'($urandom) & ($urandom_range(0, 1) ? 64'h888 : 64'h0),
                    {$urandom, $urandom}, {$urandom, $urandom});
            start($urandom_range(0, 7) != 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            finish();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
